prime_run_ctrl: RTL and testbench

PRIME_RUN_CTRL -- requirements
Module: prime_run_ctrl

---
 rtl/prime_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_prime_run_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prime_run_ctrl.sv
// prime_run_ctrl: mode/pacing controller for a prime sieve/scan engine.
// Keys select one of four modes. The engine is then reset, allowed to sieve,
// and stepped through primes either once per SEC_CYCLES (paced) or as fast
// as it acknowledges (free-run), until it reports that the scan is finished.
module prime_run_ctrl #(
    parameter int SEC_CYCLES   = 50_000_000,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rstn_signal,
    input  logic [3:0]  key_pulse,
    input  logic        sieve_done,
    input  logic        step_ack,
    input  logic        scan_end,
    output logic        eng_rstn,
    output logic        dir_up,
    output logic        adv_req,
    output logic [3:0]  led,
    output logic [2:0]  state_o,
    output logic [19:0] prime_cnt
);

    localparam int STEP_W  = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SEC_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        SIEVE = 3'd2,
        WAIT  = 3'd3,
        REQ   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         mode_reg, mode_next;
    logic [3:0]         led_reg, led_next;
    logic               dir_up_reg, dir_up_next;
    logic [19:0]        prime_cnt_reg, prime_cnt_next;
    logic [FLUSH_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic [STEP_W-1:0]  step_cnt_reg, step_cnt_next;

    logic       key_hit;
    logic [1:0] key_idx;

    // Keys are active-low; the lowest-numbered pressed key wins.
    always_comb begin
        key_hit = ~&key_pulse;
        key_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!key_pulse[i]) key_idx = 2'(i);
        end
    end

    // State and datapath registers, cleared asynchronously so a reset aborts at once.
    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            state_reg     <= IDLE;
            mode_reg      <= 2'd0;
            led_reg       <= 4'b1111;
            dir_up_reg    <= 1'b1;
            prime_cnt_reg <= 20'd0;
            flush_cnt_reg <= '0;
            step_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            led_reg       <= led_next;
            dir_up_reg    <= dir_up_next;
            prime_cnt_reg <= prime_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
            step_cnt_reg  <= step_cnt_next;
        end
    end

    // Next-state logic; a key press overrides whatever the current state decided.
    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        led_next       = led_reg;
        dir_up_next    = dir_up_reg;
        prime_cnt_next = prime_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        step_cnt_next  = step_cnt_reg;

        case (state_reg)
            FLUSH: begin
                if (flush_cnt_reg == FLUSH_LAST) state_next = SIEVE;
                else flush_cnt_next = flush_cnt_reg + 1'b1;
            end
            SIEVE: begin
                if (sieve_done) begin
                    state_next    = WAIT;
                    step_cnt_next = '0;
                end
            end
            WAIT: begin
                if (scan_end) begin
                    state_next = DONE;
                end else if (mode_reg[1]) begin
                    // Free-run: a single cycle between requests.
                    state_next = REQ;
                end else if (step_cnt_reg == STEP_LAST) begin
                    state_next = REQ;
                end else begin
                    step_cnt_next = step_cnt_reg + 1'b1;
                end
            end
            REQ: begin
                // The count still advances when scan_end wins the same cycle.
                if (step_ack && prime_cnt_reg != 20'hFFFFF)
                    prime_cnt_next = prime_cnt_reg + 20'd1;
                if (scan_end) begin
                    state_next = DONE;
                end else if (step_ack) begin
                    state_next    = WAIT;
                    step_cnt_next = '0;
                end
            end
            default: ; // IDLE and DONE wait for a key
        endcase

        if (key_hit) begin
            state_next     = FLUSH;
            mode_next      = key_idx;
            led_next       = ~(4'b0001 << key_idx);
            dir_up_next    = ~key_idx[0];
            prime_cnt_next = 20'd0;
            flush_cnt_next = '0;
        end
    end

    assign eng_rstn  = !(state_reg == IDLE || state_reg == FLUSH);
    assign adv_req   = (state_reg == REQ);
    assign led       = led_reg;
    assign dir_up    = dir_up_reg;
    assign prime_cnt = prime_cnt_reg;
    assign state_o   = state_reg;

endmodule

// File: tb/tb_prime_run_ctrl.sv
// Testbench for prime_run_ctrl with SEC_CYCLES=10, FLUSH_CYCLES=4.
module tb_prime_run_ctrl;

    logic        clk = 1'b0;
    logic        rstn_signal;
    logic [3:0]  key_pulse;
    logic        sieve_done, step_ack, scan_end;
    logic        eng_rstn, dir_up, adv_req;
    logic [3:0]  led;
    logic [2:0]  state_o;
    logic [19:0] prime_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int model_cnt = 0;
    logic [19:0] exp_q[$];

    prime_run_ctrl #(.SEC_CYCLES(10), .FLUSH_CYCLES(4)) dut (
        .clk(clk), .rstn_signal(rstn_signal), .key_pulse(key_pulse),
        .sieve_done(sieve_done), .step_ack(step_ack), .scan_end(scan_end),
        .eng_rstn(eng_rstn), .dir_up(dir_up), .adv_req(adv_req),
        .led(led), .state_o(state_o), .prime_cnt(prime_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        key_pulse = k;
        tick();
        key_pulse = 4'b1111;
        $display("key %b -> led=%b dir_up=%0b state=%0d", k, led, dir_up, state_o);
    endtask

    // Counts FLUSH cycles (eng_rstn low) starting at the current negedge.
    task automatic count_flush(input string name, input logic exp_dir);
        int n = 0;
        logic dir_bad = 1'b0;
        while (eng_rstn == 1'b0 && n < 20) begin
            if (dir_up !== exp_dir) dir_bad = 1'b1;
            tick();
            n++;
        end
        total++;
        if (n != 4) begin bad++; $display("FAIL %s_flush_len got=%0d want=4", name, n); end
        total++;
        if (dir_bad) begin bad++; $display("FAIL %s_dir_stable want=%0b", name, exp_dir); end
        total++;
        if (state_o !== 3'd2 && state_o !== 3'd3) begin
            bad++; $display("FAIL %s_after_flush state=%0d want=2or3", name, state_o);
        end
        $display("%s: flush lasted %0d cycles", name, n);
    endtask

    task automatic wait_adv(input string name, output int t);
        int n = 0;
        while (adv_req !== 1'b1 && n < 100) begin tick(); n++; end
        t = cyc;
        total++;
        if (adv_req !== 1'b1) begin bad++; $display("FAIL %s_adv_timeout got=%0b want=1", name, adv_req); end
    endtask

    // Engine-style ack one cycle after the request is seen; scoreboard checks the count.
    task automatic ack_step(input string name, input logic with_end);
        logic [19:0] e;
        tick();
        step_ack = 1'b1;
        scan_end = with_end;
        if (model_cnt < 20'hFFFFF) model_cnt++;
        exp_q.push_back(20'(model_cnt));
        tick();
        step_ack = 1'b0;
        scan_end = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (prime_cnt !== e) begin bad++; $display("FAIL %s_cnt got=%0d want=%0d", name, prime_cnt, e); end
        total++;
        if (adv_req !== 1'b0) begin bad++; $display("FAIL %s_adv_drop got=%0b want=0", name, adv_req); end
        $display("%s: ack -> prime_cnt=%0d state=%0d", name, prime_cnt, state_o);
    endtask

    task automatic test_reset();
        rstn_signal = 1'b0; key_pulse = 4'b1111;
        sieve_done = 1'b0; step_ack = 1'b0; scan_end = 1'b0;
        repeat (3) tick();
        total++;
        if ({led, eng_rstn, adv_req, dir_up, state_o, prime_cnt} !== {4'b1111, 1'b0, 1'b0, 1'b1, 3'd0, 20'd0}) begin
            bad++; $display("FAIL reset_values led=%b eng=%0b adv=%0b dir=%0b st=%0d cnt=%0d", led, eng_rstn, adv_req, dir_up, state_o, prime_cnt);
        end
        rstn_signal = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({led, eng_rstn, adv_req, state_o} !== {4'b1111, 1'b0, 1'b0, 3'd0}) begin
                bad++; $display("FAIL idle_hold led=%b eng=%0b adv=%0b st=%0d", led, eng_rstn, adv_req, state_o);
            end
        end
        $display("reset: idle held 20 cycles");
    endtask

    task automatic test_paced_mode0();
        int n = 0;
        press(4'b1110);
        model_cnt = 0;
        total++;
        if ({led, dir_up, state_o} !== {4'b1110, 1'b1, 3'd1}) begin
            bad++; $display("FAIL m0_start led=%b dir=%0b st=%0d want 1110/1/1", led, dir_up, state_o);
        end
        count_flush("m0", 1'b1);
        sieve_done = 1'b1;
        tick();
        total++;
        if (state_o !== 3'd3) begin bad++; $display("FAIL m0_wait_entry state=%0d want=3", state_o); end
        while (adv_req !== 1'b1 && n < 50) begin tick(); n++; end
        total++;
        if (n != 10) begin bad++; $display("FAIL m0_pace got=%0d want=10", n); end
        $display("m0: first request %0d cycles after WAIT", n);
        ack_step("m0", 1'b0);
        // ack outside REQ is ignored
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        total++;
        if (prime_cnt !== 20'd1 || state_o !== 3'd3) begin
            bad++; $display("FAIL m0_stray_ack cnt=%0d st=%0d want 1/3", prime_cnt, state_o);
        end
    endtask

    task automatic test_freerun_mode3();
        int t, t_prev;
        press(4'b0111);
        model_cnt = 0;
        total++;
        if ({led, dir_up} !== {4'b0111, 1'b0}) begin
            bad++; $display("FAIL m3_start led=%b dir=%0b want 0111/0", led, dir_up);
        end
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_adv("m3", t);
            if (i > 0) begin
                total++;
                if (t - t_prev != 3) begin bad++; $display("FAIL m3_period got=%0d want=3", t - t_prev); end
            end
            t_prev = t;
            ack_step("m3", 1'b0);
        end
        total++;
        if (prime_cnt !== 20'd5 || dir_up !== 1'b0) begin
            bad++; $display("FAIL m3_final cnt=%0d dir=%0b want 5/0", prime_cnt, dir_up);
        end
    endtask

    task automatic test_key_in_req();
        int t;
        wait_adv("kreq", t);
        press(4'b0011);
        model_cnt = 0;
        total++;
        if ({led, adv_req, prime_cnt, state_o, dir_up} !== {4'b1011, 1'b0, 20'd0, 3'd1, 1'b1}) begin
            bad++; $display("FAIL kreq_mode2 led=%b adv=%0b cnt=%0d st=%0d dir=%0b", led, adv_req, prime_cnt, state_o, dir_up);
        end
        repeat (2) tick();
        press(4'b1101);
        count_flush("restart", 1'b0);
    endtask

    task automatic test_scan_end();
        int t;
        wait_adv("scan", t);
        ack_step("scan", 1'b1);
        total++;
        if (state_o !== 3'd5) begin bad++; $display("FAIL scan_done state=%0d want=5", state_o); end
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        repeat (3) tick();
        total++;
        if ({prime_cnt, state_o, adv_req, led} !== {20'd1, 3'd5, 1'b0, 4'b1101}) begin
            bad++; $display("FAIL done_hold cnt=%0d st=%0d adv=%0b led=%b", prime_cnt, state_o, adv_req, led);
        end
        $display("scan_end: DONE with prime_cnt=%0d", prime_cnt);
    endtask

    task automatic test_async_reset();
        int t;
        press(4'b1101);
        model_cnt = 0;
        wait_adv("arst", t);
        ack_step("arst", 1'b0);
        repeat (3) tick();
        #2 rstn_signal = 1'b0;
        #1;
        total++;
        if ({led, eng_rstn, prime_cnt, state_o, adv_req} !== {4'b1111, 1'b0, 20'd0, 3'd0, 1'b0}) begin
            bad++; $display("FAIL async_reset led=%b eng=%0b cnt=%0d st=%0d", led, eng_rstn, prime_cnt, state_o);
        end
        tick();
        rstn_signal = 1'b1;
        repeat (5) tick();
        total++;
        if (state_o !== 3'd0 || eng_rstn !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle st=%0d eng=%0b", state_o, eng_rstn);
        end
        $display("async reset: led=%b state=%0d", led, state_o);
    endtask

    initial begin
        test_reset();
        test_paced_mode0();
        test_freerun_mode3();
        test_key_in_req();
        test_scan_end();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
